// File: rtl/ps2_mouse_tracker_if.sv
// Byte-stream input and decoded mouse-state outputs of the PS/2 mouse tracker.
interface ps2_mouse_tracker_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic        mouse_right;
    logic        pkt_valid;
    logic        sync_err;

    modport master (
        output rx_data, rx_valid,
        input  mouse_xpos, mouse_ypos, mouse_left, mouse_right, pkt_valid, sync_err
    );

    modport slave (
        input  rx_data, rx_valid,
        output mouse_xpos, mouse_ypos, mouse_left, mouse_right, pkt_valid, sync_err
    );
endinterface

// File: rtl/ps2_mouse_tracker.sv
// Assembles 3-byte PS/2 mouse packets into a clamped cursor position and button state.
// Optional inter-byte timeout abort is enabled with `define MOUSE_TIMEOUT_EN.
module ps2_mouse_tracker #(
    parameter int unsigned XMAX           = 799,
    parameter int unsigned YMAX           = 599,
    parameter int unsigned XINIT          = 400,
    parameter int unsigned YINIT          = 300,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input logic                clk,
    input logic                rst,
    ps2_mouse_tracker_if.slave bus
);

    typedef enum logic [1:0] {StB0, StB1, StB2} state_e;

    localparam logic signed [12:0] XMaxS = 13'(XMAX);
    localparam logic signed [12:0] YMaxS = 13'(YMAX);

    state_e      state_q, state_d;
    logic [7:0]  status_q, status_d;
    logic [7:0]  dx_q, dx_d;
    logic [11:0] xpos_q, xpos_d;
    logic [11:0] ypos_q, ypos_d;
    logic        left_q, left_d;
    logic        right_q, right_d;
    logic        pkt_q, pkt_d;
    logic        err_q, err_d;
    logic        timeout;

    logic        [8:0]  dx9, dy9;
    logic signed [12:0] x_sum, y_sum;
    logic        [11:0] x_clamp, y_clamp;

    // Overflowed axes contribute no motion; dy comes straight from the byte being accepted.
    assign dx9   = status_q[6] ? 9'd0 : {status_q[4], dx_q};
    assign dy9   = status_q[7] ? 9'd0 : {status_q[5], bus.rx_data};
    assign x_sum = $signed({1'b0, xpos_q}) + $signed({{4{dx9[8]}}, dx9});
    assign y_sum = $signed({1'b0, ypos_q}) - $signed({{4{dy9[8]}}, dy9});

    always_comb begin
        x_clamp = x_sum[11:0];
        if (x_sum < 0) begin
            x_clamp = '0;
        end else if (x_sum > XMaxS) begin
            x_clamp = XMaxS[11:0];
        end
        y_clamp = y_sum[11:0];
        if (y_sum < 0) begin
            y_clamp = '0;
        end else if (y_sum > YMaxS) begin
            y_clamp = YMaxS[11:0];
        end
    end

`ifdef MOUSE_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // A byte arriving on the limit cycle wins over the abort.
    assign timeout = (state_q != StB0) && !bus.rx_valid && (cnt_q == CntW'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (state_q == StB0 || bus.rx_valid || timeout) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        dx_d     = dx_q;
        xpos_d   = xpos_q;
        ypos_d   = ypos_q;
        left_d   = left_q;
        right_d  = right_q;
        pkt_d    = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            StB0: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data[3]) begin
                        status_d = bus.rx_data;
                        state_d  = StB1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StB1: begin
                if (bus.rx_valid) begin
                    dx_d    = bus.rx_data;
                    state_d = StB2;
                end else if (timeout) begin
                    state_d = StB0;
                    err_d   = 1'b1;
                end
            end
            StB2: begin
                if (bus.rx_valid) begin
                    state_d = StB0;
                    xpos_d  = x_clamp;
                    ypos_d  = y_clamp;
                    left_d  = status_q[0];
                    right_d = status_q[1];
                    pkt_d   = 1'b1;
                end else if (timeout) begin
                    state_d = StB0;
                    err_d   = 1'b1;
                end
            end
            default: state_d = StB0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StB0;
            status_q <= '0;
            dx_q     <= '0;
            xpos_q   <= 12'(XINIT);
            ypos_q   <= 12'(YINIT);
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            pkt_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            dx_q     <= dx_d;
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            left_q   <= left_d;
            right_q  <= right_d;
            pkt_q    <= pkt_d;
            err_q    <= err_d;
        end
    end

    assign bus.mouse_xpos  = xpos_q;
    assign bus.mouse_ypos  = ypos_q;
    assign bus.mouse_left  = left_q;
    assign bus.mouse_right = right_q;
    assign bus.pkt_valid   = pkt_q;
    assign bus.sync_err    = err_q;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed self-checking bench for ps2_mouse_tracker; timeout expectations follow MOUSE_TIMEOUT_EN.
module tb_ps2_mouse_tracker;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   pkt_cnt;
    int   err_cnt;

    ps2_mouse_tracker_if bus ();

    ps2_mouse_tracker #(
        .XMAX          (799),
        .YMAX          (599),
        .XINIT         (400),
        .YINIT         (300),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs move on posedge; counting pulses on negedge keeps sampling away from it.
    always @(negedge clk) begin
        if (bus.pkt_valid) pkt_cnt++;
        if (bus.sync_err) err_cnt++;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        pkt_cnt = 0;
        err_cnt = 0;
    endtask

    // Drives a one-cycle strobe; returns at the negedge right after it, where results are visible.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        pkt_cnt      = 0;
        err_cnt      = 0;
        rst          = 1'b0;
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;

        do_reset();
        check_eq("rst_xpos", bus.mouse_xpos, 400);
        check_eq("rst_ypos", bus.mouse_ypos, 300);
        check_eq("rst_left", bus.mouse_left, 0);
        check_eq("rst_right", bus.mouse_right, 0);
        check_eq("rst_pkt", bus.pkt_valid, 0);
        check_eq("rst_err", bus.sync_err, 0);

        // Basic packet, one-cycle latency, single-cycle pkt_valid
        send_byte(8'h09);
        send_byte(8'h05);
        check_eq("b1_no_pkt", bus.pkt_valid, 0);
        send_byte(8'h03);
        check_eq("basic_pkt", bus.pkt_valid, 1);
        check_eq("basic_xpos", bus.mouse_xpos, 405);
        check_eq("basic_ypos", bus.mouse_ypos, 297);
        check_eq("basic_left", bus.mouse_left, 1);
        check_eq("basic_right", bus.mouse_right, 0);
        @(negedge clk);
        check_eq("basic_pkt_drop", bus.pkt_valid, 0);
        repeat (3) @(negedge clk);
        check_eq("basic_pkt_cnt", pkt_cnt, 1);
        check_eq("hold_xpos", bus.mouse_xpos, 405);

        // Large negative moves and clamping at both edges
        do_reset();
        send_byte(8'h38);
        send_byte(8'h00);
        send_byte(8'h00);
        check_eq("neg_xpos", bus.mouse_xpos, 144);
        check_eq("neg_ypos", bus.mouse_ypos, 556);
        send_byte(8'h38);
        send_byte(8'h00);
        send_byte(8'h00);
        check_eq("clamp_xpos", bus.mouse_xpos, 0);
        check_eq("clamp_ypos", bus.mouse_ypos, 599);

        // Out-of-sync byte dropped, then a good packet
        do_reset();
        send_byte(8'h04);
        check_eq("drop_err", bus.sync_err, 1);
        send_byte(8'h0A);
        check_eq("drop_err_clear", bus.sync_err, 0);
        send_byte(8'h10);
        send_byte(8'h00);
        check_eq("resync_xpos", bus.mouse_xpos, 416);
        check_eq("resync_ypos", bus.mouse_ypos, 300);
        check_eq("resync_right", bus.mouse_right, 1);
        check_eq("resync_left", bus.mouse_left, 0);
        check_eq("resync_err_cnt", err_cnt, 1);

        // X overflow zeroes dx only
        do_reset();
        send_byte(8'h48);
        send_byte(8'h7F);
        send_byte(8'h01);
        check_eq("ovf_xpos", bus.mouse_xpos, 400);
        check_eq("ovf_ypos", bus.mouse_ypos, 299);

        // Inter-byte gap after a status byte
        do_reset();
        send_byte(8'h08);
        repeat (20) @(negedge clk);
        send_byte(8'h09);
        send_byte(8'h01);
        send_byte(8'h00);
        @(negedge clk);
        check_eq("gap_err_cnt", err_cnt, 1);
`ifdef MOUSE_TIMEOUT_EN
        check_eq("gap_xpos", bus.mouse_xpos, 401);
        check_eq("gap_ypos", bus.mouse_ypos, 300);
        check_eq("gap_left", bus.mouse_left, 1);
`else
        check_eq("gap_xpos", bus.mouse_xpos, 409);
        check_eq("gap_ypos", bus.mouse_ypos, 299);
        check_eq("gap_left", bus.mouse_left, 0);
`endif
        check_eq("gap_pkt_cnt", pkt_cnt, 1);

        // Reset mid-packet discards it silently
        do_reset();
        send_byte(8'h08);
        send_byte(8'h05);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("midrst_pkt_cnt", pkt_cnt, 0);
        check_eq("midrst_err_cnt", err_cnt, 0);
        check_eq("midrst_xpos", bus.mouse_xpos, 400);
        send_byte(8'h08);
        send_byte(8'h01);
        send_byte(8'h01);
        check_eq("midrst_new_xpos", bus.mouse_xpos, 401);
        check_eq("midrst_new_ypos", bus.mouse_ypos, 299);

        // Reset wins over a coincident strobe
        @(negedge clk);
        rst          = 1'b1;
        bus.rx_data  = 8'h09;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.rx_valid = 1'b0;
        send_byte(8'h05);
        send_byte(8'h03);
        check_eq("rstpri_pkt", bus.pkt_valid, 0);
        check_eq("rstpri_xpos", bus.mouse_xpos, 400);
        check_eq("rstpri_err", bus.sync_err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
